// File: rtl/pcileech_com_pkg.sv
// Shared definitions for the PCILeech COM-core RX path: the in-band resync
// word and the RX front-end state encoding.
package pcileech_com_pkg;

    // Two of these back-to-back on the link abort the partial group.
    localparam logic [31:0] COM_MAGIC_RESYNC = 32'h6666_5555;

    typedef enum logic [1:0] {
        S_DELAY = 2'd0,  // quiet period after reset release
        S_INIT  = 2'd1,  // injecting the boot-time word table
        S_RUN   = 2'd2   // forwarding packed link data from the FIFO
    } com_rx_state_t;

endpackage

// File: rtl/pcileech_com_rx_obuf.sv
// Single-clock fall-through FIFO: dout shows the head word whenever valid is
// high, pop consumes it. A push while full is accepted only if a pop frees a
// slot in the same cycle. DEPTH must be a power of two (>= 2).
module pcileech_com_rx_obuf #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             push,
    output logic             full,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    input  logic             pop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_en;
    logic             rd_en;

    // Status flags, effective read/write enables and the fall-through head.
    always_comb begin
        valid = (count_q != '0);
        full  = (count_q == (AW+1)'(DEPTH));
        rd_en = pop & valid;
        wr_en = push & (~full | rd_en);
        dout  = mem_q[rd_ptr_q];
    end

    // Storage array write.
    // NOTE: the data array is deliberately not reset; only pointers and the
    // occupancy count must be defined, and a reset here would block RAM mapping.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pcileech_com_rx_packer.sv
// COM-core RX front end. Packs RATIO link words (IN_W bits each, first word
// in the MSBs) into OUT_W-bit words, injects INIT_WORDS boot words after an
// INIT_DELAY-cycle quiet period, and resyncs on two consecutive MAGIC words.
// Packed words are buffered in pcileech_com_rx_obuf and drained in S_RUN.
// Optional: define PCILEECH_COM_RX_STATS_EN to add the saturating
// stat_resync / stat_drop counter ports. Requires INIT_DELAY >= 1.
module pcileech_com_rx_packer
    import pcileech_com_pkg::*;
#(
    parameter int              IN_W       = 32,
    parameter int              RATIO      = 2,
    parameter logic [IN_W-1:0] MAGIC      = IN_W'(COM_MAGIC_RESYNC),
    parameter int              INIT_DELAY = 16,
    parameter int              INIT_WORDS = 5,
    parameter int              OBUF_DEPTH = 4,
    localparam int             OUT_W      = IN_W * RATIO
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [IN_W-1:0]             in_data,
    input  logic                        in_valid,
    input  logic [INIT_WORDS*OUT_W-1:0] init_data,
    output logic [OUT_W-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        init_done,
    output logic                        overflow
`ifdef PCILEECH_COM_RX_STATS_EN
    ,
    output logic [15:0]                 stat_resync,
    output logic [15:0]                 stat_drop
`endif
);

    localparam int DLY_W = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
    localparam int IDX_W = (INIT_WORDS > 1) ? $clog2(INIT_WORDS) : 1;
    localparam int CNT_W = $clog2(RATIO);

    com_rx_state_t    state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             init_done_q, init_done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [IN_W-1:0]  last_word_q, last_word_d;
    logic             last_valid_q, last_valid_d;
    logic             overflow_q, overflow_d;

    logic [OUT_W-1:0] init_word;
    logic [OUT_W-1:0] acc_shift;
    logic             resync;
    logic             push_req;
    logic             pop;
    logic             drop;
    logic             obuf_full;
    logic             obuf_valid;
    logic [OUT_W-1:0] obuf_dout;

    // FSM state register plus the counters it owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_DELAY;
            dly_q       <= '0;
            idx_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
        end
    end

    // FSM next state: wait out the delay, step through the init table on
    // each handshake, then stay in S_RUN until reset.
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves a variable unassigned (which would infer a latch).
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        unique case (state_q)
            S_DELAY: begin
                if (dly_q == DLY_W'(INIT_DELAY - 1)) state_d = S_INIT;
                else                                 dly_d   = dly_q + 1'b1;
            end
            S_INIT: begin
                // out_valid is constantly high here, so out_ready is the handshake.
                if (out_ready) begin
                    if (idx_q == IDX_W'(INIT_WORDS - 1)) begin
                        state_d     = S_RUN;
                        init_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_DELAY;
        endcase
    end

    // Select the init table entry addressed by idx_q.
    always_comb begin
        init_word = '0;
        for (int k = 0; k < INIT_WORDS; k++) begin
            if (idx_q == IDX_W'(k)) init_word = init_data[k*OUT_W +: OUT_W];
        end
    end

    // FSM outputs: nothing in S_DELAY, the init table in S_INIT, FIFO head in S_RUN.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        pop       = 1'b0;
        unique case (state_q)
            S_INIT: begin
                out_valid = 1'b1;
                out_data  = init_word;
            end
            S_RUN: begin
                out_valid = obuf_valid;
                out_data  = obuf_valid ? obuf_dout : '0;
                pop       = obuf_valid & out_ready;
            end
            default: ;
        endcase
    end

    // Packer next state: resync detection, LSB shift-in and group completion.
    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        last_word_d  = last_word_q;
        last_valid_d = last_valid_q;
        push_req     = 1'b0;
        acc_shift    = {acc_q[OUT_W-IN_W-1:0], in_data};
        resync       = in_valid & (in_data == MAGIC) & last_valid_q & (last_word_q == MAGIC);
        if (in_valid) begin
            last_word_d  = in_data;
            last_valid_d = 1'b1;
            if (resync) begin
                cnt_d = '0;
            end else begin
                acc_d = acc_shift;
                if (cnt_q == CNT_W'(RATIO - 1)) begin
                    push_req = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // A completed word is lost only if the FIFO is full and no pop frees a slot.
    always_comb begin
        drop       = push_req & obuf_full & ~pop;
        overflow_d = overflow_q | drop;
    end

    // Packer and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            last_word_q  <= '0;
            last_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            last_word_q  <= last_word_d;
            last_valid_q <= last_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign init_done = init_done_q;
    assign overflow  = overflow_q;

    pcileech_com_rx_obuf #(
        .WIDTH (OUT_W),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (acc_shift),
        .push  (push_req),
        .full  (obuf_full),
        .dout  (obuf_dout),
        .valid (obuf_valid),
        .pop   (pop)
    );

`ifdef PCILEECH_COM_RX_STATS_EN
    logic [15:0] stat_resync_q;
    logic [15:0] stat_drop_q;

    // Saturating event counters for resyncs and dropped words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resync_q <= '0;
            stat_drop_q   <= '0;
        end else begin
            if (resync && (stat_resync_q != 16'hFFFF)) stat_resync_q <= stat_resync_q + 16'd1;
            if (drop && (stat_drop_q != 16'hFFFF))     stat_drop_q   <= stat_drop_q + 16'd1;
        end
    end

    assign stat_resync = stat_resync_q;
    assign stat_drop   = stat_drop_q;
`endif

endmodule
